bus_ic: RTL and testbench

Parametrised shared-bus interconnect between N bus masters and M bus slaves, implementing the master-side (`ic`) and slave-side (`ic`) roles of the system bus. It performs:

- round-robin arbitration over `breq`/`bgnt`;
- mask/base address decoding to a one-hot slave select;
- registered forwarding of the request phase, and combinational return of the response phase;
- decode-error and optional timeout-error generation.

It sits between the core/debug masters and the memory and peripheral slaves.

---
 rtl/bus_ic.sv | 229 ++++++++++++++++++++++
 tb/tb_bus_ic.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ic.sv
// bus_ic: shared-bus interconnect between N_M masters and N_S slaves.
// Round-robin grant, mask/base decode to a one-hot slave select, registered
// request phase and combinational response phase. Decode errors are answered
// locally. Define BUS_IC_TIMEOUT_EN to add a response timeout on BUSY.
module bus_ic #(
  parameter int N_M = 2,
  parameter int N_S = 3,
  parameter logic [32*N_S-1:0] S_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [32*N_S-1:0] S_MASK = {3{32'hF000_0000}},
  parameter int TIMEOUT = 255
) (
  input  logic               bclk,
  input  logic               brst_n,
  input  logic [N_M-1:0]     m_breq,
  output logic [N_M-1:0]     m_bgnt,
  input  logic [N_M-1:0]     m_bstart,
  input  logic [N_M-1:0]     m_bwrite,
  input  logic [32*N_M-1:0]  m_addr,
  input  logic [32*N_M-1:0]  m_wdata,
  input  logic [2*N_M-1:0]   m_tsize,
  output logic [31:0]        m_rdata,
  output logic [N_M-1:0]     m_bdone,
  output logic [N_M-1:0]     m_berror,
  output logic [N_S-1:0]     s_ss,
  output logic               s_bstart,
  output logic               s_bwrite,
  output logic [31:0]        s_addr,
  output logic [31:0]        s_wdata,
  output logic [1:0]         s_tsize,
  input  logic [32*N_S-1:0]  s_rdata,
  input  logic [N_S-1:0]     s_bdone,
  input  logic [N_S-1:0]     s_berror
);

  localparam int MW = (N_M > 1) ? $clog2(N_M) : 1;
  localparam int SW = (N_S > 1) ? $clog2(N_S) : 1;
  localparam logic [MW-1:0] LAST_RST = MW'(N_M - 1);

  if (N_M < 1 || N_S < 1 || TIMEOUT < 8 || TIMEOUT > 65535) begin : g_param_chk
    $error("bus_ic: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, OWNED, BUSY} state_t;

  state_t          r_state;
  logic [MW-1:0]   r_owner;
  logic [MW-1:0]   r_last;
  logic [SW-1:0]   r_k;
  logic [N_M-1:0]  r_bgnt;
  logic [N_S-1:0]  r_ss;
  logic            r_sbstart;
  logic            r_bwrite;
  logic            r_derr;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [1:0]      r_tsize;

  logic            w_own_req, w_own_start, w_own_write;
  logic [31:0]     w_own_addr, w_own_wdata;
  logic [1:0]      w_own_tsize;
  logic            w_any;
  logic [MW-1:0]   w_win;
  int              w_best;
  logic            w_hit;
  logic [SW-1:0]   w_hit_k;
  logic            w_sdone, w_serr;
  logic [31:0]     w_srdata;
  logic            w_tmo;
  logic            w_busy_end;

  // Current owner's request signals, picked out of the packed master buses
  always_comb begin
    w_own_req   = 1'b0;
    w_own_start = 1'b0;
    w_own_write = 1'b0;
    w_own_addr  = '0;
    w_own_wdata = '0;
    w_own_tsize = '0;
    for (int i = 0; i < N_M; i++) begin
      if (r_owner == MW'(i)) begin
        w_own_req   = m_breq[i];
        w_own_start = m_bstart[i];
        w_own_write = m_bwrite[i];
        w_own_addr  = m_addr[i*32 +: 32];
        w_own_wdata = m_wdata[i*32 +: 32];
        w_own_tsize = m_tsize[i*2 +: 2];
      end
    end
  end

  // Round-robin pick: requester with the smallest distance past r_last wins
  always_comb begin
    w_any  = |m_breq;
    w_win  = r_last;
    w_best = N_M;
    for (int i = 0; i < N_M; i++) begin
      if (m_breq[i] && (((i + N_M - int'(r_last) - 1) % N_M) < w_best)) begin
        w_best = (i + N_M - int'(r_last) - 1) % N_M;
        w_win  = MW'(i);
      end
    end
  end

  // Address decode of the owner's address; scanning downward lets slave 0 win overlaps
  always_comb begin
    w_hit   = 1'b0;
    w_hit_k = '0;
    for (int k = N_S - 1; k >= 0; k--) begin
      if ((w_own_addr & S_MASK[k*32 +: 32]) == S_BASE[k*32 +: 32]) begin
        w_hit   = 1'b1;
        w_hit_k = SW'(k);
      end
    end
  end

  // Response of the latched slave
  always_comb begin
    w_sdone  = 1'b0;
    w_serr   = 1'b0;
    w_srdata = '0;
    for (int k = 0; k < N_S; k++) begin
      if (r_k == SW'(k)) begin
        w_sdone  = s_bdone[k];
        w_serr   = s_berror[k];
        w_srdata = s_rdata[k*32 +: 32];
      end
    end
  end

`ifdef BUS_IC_TIMEOUT_EN
  logic [15:0] r_cnt;
  // A genuine s_bdone in the same cycle takes precedence over the timeout
  assign w_tmo = (r_state == BUSY) && !w_sdone && (r_cnt == 16'(TIMEOUT));
`else
  assign w_tmo = 1'b0;
`endif

  assign w_busy_end = (r_state == BUSY) && (w_sdone || w_tmo);

  // Completion is steered to the owner in the same cycle as the slave response
  always_comb begin
    m_bdone  = '0;
    m_berror = '0;
    for (int i = 0; i < N_M; i++) begin
      if (r_owner == MW'(i)) begin
        m_bdone[i]  = r_derr | w_busy_end;
        m_berror[i] = r_derr | w_tmo | ((r_state == BUSY) && w_sdone && w_serr);
      end
    end
  end

  assign m_rdata  = (r_state == BUSY) ? w_srdata : '0;
  assign m_bgnt   = r_bgnt;
  assign s_ss     = r_ss;
  assign s_bstart = r_sbstart;
  assign s_bwrite = r_bwrite;
  assign s_addr   = r_addr;
  assign s_wdata  = r_wdata;
  assign s_tsize  = r_tsize;

  // Arbitration / transfer FSM with registered grant and request-phase outputs
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_last    <= LAST_RST;
      r_k       <= '0;
      r_bgnt    <= '0;
      r_ss      <= '0;
      r_sbstart <= 1'b0;
      r_bwrite  <= 1'b0;
      r_derr    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tsize   <= '0;
`ifdef BUS_IC_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_sbstart <= 1'b0;
      r_derr    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_bgnt  <= N_M'(1) << w_win;
            r_state <= OWNED;
          end
        end
        OWNED: begin
          if (!w_own_req) begin
            r_bgnt  <= '0;
            r_last  <= r_owner;
            r_state <= IDLE;
          end else if (w_own_start) begin
            if (w_hit) begin
              r_k       <= w_hit_k;
              r_ss      <= N_S'(1) << w_hit_k;
              r_sbstart <= 1'b1;
              r_bwrite  <= w_own_write;
              r_addr    <= w_own_addr;
              r_wdata   <= w_own_wdata;
              r_tsize   <= w_own_tsize;
              r_state   <= BUSY;
`ifdef BUS_IC_TIMEOUT_EN
              r_cnt     <= '0;
`endif
            end else begin
              r_derr <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (w_busy_end) begin
            r_ss    <= '0;
            r_state <= OWNED;
          end
`ifdef BUS_IC_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ic.sv
// Bench for bus_ic: tasks per scenario, randomized transfers checked against a
// reference model (decode table, round-robin pointer, expected handshakes).
module tb_bus_ic;

`ifdef BUS_IC_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic        bclk, brst_n;
  logic [1:0]  m_breq, m_bgnt, m_bstart, m_bwrite, m_bdone, m_berror;
  logic [63:0] m_addr, m_wdata;
  logic [3:0]  m_tsize;
  logic [31:0] m_rdata;
  logic [2:0]  s_ss, s_bdone, s_berror;
  logic        s_bstart, s_bwrite;
  logic [31:0] s_addr, s_wdata;
  logic [1:0]  s_tsize;
  logic [95:0] s_rdata;

  int n_vec = 0;
  int n_err = 0;
  int mdl_last;

  localparam logic [31:0] BASE [3] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};

  bus_ic #(.TIMEOUT(TMO)) dut (
    .bclk(bclk), .brst_n(brst_n),
    .m_breq(m_breq), .m_bgnt(m_bgnt), .m_bstart(m_bstart), .m_bwrite(m_bwrite),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_tsize(m_tsize), .m_rdata(m_rdata),
    .m_bdone(m_bdone), .m_berror(m_berror),
    .s_ss(s_ss), .s_bstart(s_bstart), .s_bwrite(s_bwrite), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_tsize(s_tsize), .s_rdata(s_rdata),
    .s_bdone(s_bdone), .s_berror(s_berror)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
    $fatal(1);
  end

  // At most one grant in any cycle
  always @(negedge bclk) begin
    if (brst_n) begin
      n_vec++;
      if ($countones(m_bgnt) > 1) begin
        n_err++;
        $display("FAIL onehot_gnt: got %b, required at most one bit", m_bgnt);
      end
    end
  end

  // Model: first slave whose mask/base matches, -1 when none does
  function automatic int exp_slave(input logic [31:0] a);
    for (int k = 0; k < 3; k++)
      if ((a & 32'hF000_0000) == BASE[k]) return k;
    return -1;
  endfunction

  // Model: round-robin winner from the last released owner
  function automatic int exp_winner(input logic [1:0] req);
    for (int off = 1; off <= 2; off++)
      if (req[(mdl_last + off) % 2]) return (mdl_last + off) % 2;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[31:28] = 4'($urandom_range(0, 3));
    return a;
  endfunction

  task automatic step();
    @(posedge bclk);
    #1;
  endtask

  task automatic mid();
    @(negedge bclk);
  endtask

  task automatic acquire(input logic [1:0] req, output int w);
    step();
    m_breq = req;
    mid();
    n_vec++;
    if (m_bgnt !== 2'b00) begin
      n_err++; $display("FAIL idle_gnt: got %b, required 00", m_bgnt);
    end
    w = exp_winner(req);
    step();
    mid();
    n_vec++;
    if (m_bgnt !== 2'(1 << w)) begin
      n_err++; $display("FAIL grant: got %b, required %b", m_bgnt, 2'(1 << w));
    end
  endtask

  task automatic release_bus(input int w);
    step();
    s_bdone = '0; s_berror = '0;
    m_breq[w] = 1'b0;
    mid();
    n_vec++;
    if (m_bgnt !== 2'(1 << w) || m_bdone !== 2'b00) begin
      n_err++; $display("FAIL release_hold: gnt %b bdone %b, required gnt %b bdone 00", m_bgnt, m_bdone, 2'(1 << w));
    end
    mdl_last = w;
  endtask

  task automatic do_xfer(input int m, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input int wt, input logic [31:0] rd, input logic er);
    int k;
    int o;
    k = exp_slave(a);
    o = 1 - m;
    step();
    s_bdone = '0; s_berror = '0;
    m_bstart[m] = 1'b1; m_bwrite[m] = wr;
    m_addr[m*32 +: 32] = a; m_wdata[m*32 +: 32] = wd; m_tsize[m*2 +: 2] = sz;
    m_bstart[o] = 1'($urandom_range(0, 1));
    m_addr[o*32 +: 32] = rand_addr();
    mid();
    n_vec++;
    if (m_bdone !== 2'b00 || s_ss !== 3'b000 || s_bstart !== 1'b0 || m_rdata !== 32'h0) begin
      n_err++; $display("FAIL start_cycle: bdone %b ss %b sbstart %b rdata %h, required 00 000 0 0", m_bdone, s_ss, s_bstart, m_rdata);
    end
    step();
    m_bstart = '0;
    s_rdata = {$urandom, $urandom, $urandom};
    if (k < 0) begin
      mid();
      n_vec++;
      if (m_bdone !== 2'(1 << m) || m_berror !== 2'(1 << m) || s_ss !== 3'b000 ||
          s_bstart !== 1'b0 || m_bgnt !== 2'(1 << m)) begin
        n_err++; $display("FAIL decode_err: bdone %b berror %b ss %b sbstart %b gnt %b, required %b %b 000 0 %b",
                          m_bdone, m_berror, s_ss, s_bstart, m_bgnt, 2'(1 << m), 2'(1 << m), 2'(1 << m));
      end
    end else begin
      s_rdata[k*32 +: 32] = rd;
      for (int c = 0; c <= wt; c++) begin
        if (c > 0) step();
        s_bdone  = (c == wt) ? 3'(1 << k) : 3'b000;
        s_berror = (c == wt && er) ? 3'(1 << k) : 3'b000;
        mid();
        n_vec++;
        if (s_ss !== 3'(1 << k) || s_bstart !== (c == 0) || s_addr !== a || s_wdata !== wd ||
            s_tsize !== sz || s_bwrite !== wr) begin
          n_err++; $display("FAIL req_phase: ss %b sbstart %b addr %h wdata %h tsize %0d wr %b, required %b %b %h %h %0d %b",
                            s_ss, s_bstart, s_addr, s_wdata, s_tsize, s_bwrite, 3'(1 << k), (c == 0), a, wd, sz, wr);
        end
        n_vec++;
        if (m_rdata !== rd || m_bdone !== ((c == wt) ? 2'(1 << m) : 2'b00) ||
            m_berror !== ((c == wt && er) ? 2'(1 << m) : 2'b00)) begin
          n_err++; $display("FAIL resp_phase: rdata %h bdone %b berror %b, required %h %b %b", m_rdata, m_bdone, m_berror,
                            rd, (c == wt) ? 2'(1 << m) : 2'b00, (c == wt && er) ? 2'(1 << m) : 2'b00);
        end
      end
    end
  endtask

  task automatic test_reset();
    brst_n = 1'b0;
    m_breq = '0; m_bstart = '0; m_bwrite = '0; m_addr = '0; m_wdata = '0; m_tsize = '0;
    s_rdata = '0; s_bdone = '0; s_berror = '0;
    repeat (3) @(posedge bclk);
    mid();
    n_vec++;
    if ({m_bgnt, m_bdone, m_berror, m_rdata, s_ss, s_bstart, s_bwrite, s_addr, s_wdata, s_tsize} !== '0) begin
      n_err++; $display("FAIL reset_outputs: gnt %b bdone %b ss %b addr %h, required all zero", m_bgnt, m_bdone, s_ss, s_addr);
    end
    step();
    brst_n = 1'b1;
    mdl_last = 1;
  endtask

  task automatic test_round_robin();
    int w;
    for (int r = 0; r < 4; r++) begin
      acquire(2'b11, w);
      n_vec++;
      if (m_bgnt !== 2'(1 << (r % 2))) begin
        n_err++; $display("FAIL rr_order: round %0d got %b, required %b", r, m_bgnt, 2'(1 << (r % 2)));
      end
      do_xfer(w, 1'b1, rand_addr() & 32'h2FFF_FFFF, $urandom, 2'd2, $urandom_range(0, 2), $urandom, 1'b0);
      release_bus(w);
    end
    step();
    m_breq = '0;
  endtask

  task automatic test_single_read();
    int w;
    acquire(2'b01, w);
    do_xfer(w, 1'b0, 32'h1000_0004, 32'h0, 2'd2, 3, 32'hDEAD_BEEF, 1'b0);
    release_bus(w);
  endtask

  task automatic test_decode_error();
    int w;
    acquire(2'b10, w);
    do_xfer(w, 1'b0, 32'h3000_0000, 32'h0, 2'd2, 0, 32'h0, 1'b0);
    do_xfer(w, 1'b1, 32'h0000_0040, 32'h1234_5678, 2'd1, 1, 32'h0, 1'b0);
    release_bus(w);
  endtask

  task automatic test_slave_error();
    int w;
    acquire(2'($urandom_range(1, 3)), w);
    do_xfer(w, 1'b0, 32'h2000_0010, 32'h0, 2'd2, 1, 32'hCAFE_0001, 1'b1);
    do_xfer(w, 1'b0, 32'h2000_0014, 32'h0, 2'd0, 0, 32'h0000_00A5, 1'b0);
    release_bus(w);
  endtask

  task automatic test_back_to_back();
    int w;
    for (int r = 0; r < 15; r++) begin
      acquire(2'($urandom_range(1, 3)), w);
      for (int t = 0; t < int'($urandom_range(1, 3)); t++)
        do_xfer(w, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 2'($urandom_range(0, 2)),
                $urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0));
      release_bus(w);
    end
  endtask

  task automatic test_timeout();
    int w;
    int hit;
    acquire(2'b01, w);
    step();
    s_bdone = '0; s_berror = '0;
    m_bstart[w] = 1'b1; m_bwrite[w] = 1'b0; m_addr[w*32 +: 32] = 32'h0000_0100;
    step();
    m_bstart = '0;
    mid();
    n_vec++;
    if (s_bstart !== 1'b1 || s_ss !== 3'b001) begin
      n_err++; $display("FAIL tmo_start: sbstart %b ss %b, required 1 001", s_bstart, s_ss);
    end
    hit = -1;
`ifdef BUS_IC_TIMEOUT_EN
    for (int c = 1; c <= TMO + 3; c++) begin
      step();
      mid();
      if (hit < 0 && m_bdone[w]) begin
        hit = c;
        n_vec++;
        if (m_berror[w] !== 1'b1) begin
          n_err++; $display("FAIL tmo_error: berror %b, required 1", m_berror[w]);
        end
      end
    end
    n_vec++;
    if (hit != TMO) begin
      n_err++; $display("FAIL tmo_latency: done after %0d cycles, required %0d", hit, TMO);
    end
    step();
    s_bdone = 3'b001;
    mid();
    n_vec++;
    if (m_bdone !== 2'b00 || s_ss !== 3'b000) begin
      n_err++; $display("FAIL tmo_late_done: bdone %b ss %b, required 00 000", m_bdone, s_ss);
    end
`else
    for (int c = 1; c <= 100; c++) begin
      step();
      mid();
      if (hit < 0 && m_bdone !== 2'b00) hit = c;
    end
    n_vec++;
    if (hit >= 0 || s_ss !== 3'b001) begin
      n_err++; $display("FAIL no_tmo_wait: done at cycle %0d ss %b, required no done and ss 001", hit, s_ss);
    end
`endif
    step();
    brst_n = 1'b0;
    m_breq = '0; s_bdone = '0;
    step();
    brst_n = 1'b1;
    mdl_last = 1;
  endtask

  task automatic test_reset_mid_busy();
    int w;
    acquire(2'b11, w);
    step();
    m_bstart[w] = 1'b1; m_bwrite[w] = 1'b1; m_addr[w*32 +: 32] = 32'h1000_0ABC;
    m_wdata[w*32 +: 32] = 32'h5555_AAAA; m_tsize[w*2 +: 2] = 2'd2;
    step();
    m_bstart = '0;
    s_rdata[32 +: 32] = 32'hDEAD_BEEF;
    mid();
    n_vec++;
    if (m_rdata !== 32'hDEAD_BEEF || s_ss !== 3'b010) begin
      n_err++; $display("FAIL rst_busy_pre: rdata %h ss %b, required deadbeef 010", m_rdata, s_ss);
    end
    #1;
    brst_n = 1'b0;
    s_bdone = 3'b010;
    #1;
    n_vec++;
    if ({m_bgnt, m_bdone, m_berror, m_rdata, s_ss, s_bstart, s_bwrite, s_addr, s_wdata, s_tsize} !== '0) begin
      n_err++; $display("FAIL async_reset: gnt %b bdone %b rdata %h ss %b addr %h wdata %h tsize %0d, required all zero",
                        m_bgnt, m_bdone, m_rdata, s_ss, s_addr, s_wdata, s_tsize);
    end
    m_breq = '0;
    step();
    s_bdone = '0;
    step();
    brst_n = 1'b1;
    mdl_last = 1;
    acquire(2'b11, w);
    n_vec++;
    if (m_bgnt !== 2'b01) begin
      n_err++; $display("FAIL post_reset_winner: got %b, required 01", m_bgnt);
    end
    do_xfer(w, 1'b0, 32'h0000_0008, 32'h0, 2'd2, 0, 32'h0BAD_F00D, 1'b0);
    release_bus(w);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_decode_error();
    test_slave_error();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
